rgb_window_column_feeder: RTL and testbench

//   Raster-order RGB pixel stream -> vertical 3x1 columns per colour channel for the 3x3 RGB systolic conv stage.

---
 rtl/rgb_window_column_feeder.sv | 126 ++++++++++++
 tb/tb_rgb_window_column_feeder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/rgb_window_column_feeder.sv
// Turns a raster-order RGB pixel stream into per-channel 3x1 vertical columns
// {row y, row y-1, row y-2} using two line buffers per pixel position.
module rgb_window_column_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pix_valid,
  input  logic                    pix_sof,
  input  logic [3*DATA_WIDTH-1:0] pix_rgb,
  output logic [3*DATA_WIDTH-1:0] input_col_r,
  output logic [3*DATA_WIDTH-1:0] input_col_g,
  output logic [3*DATA_WIDTH-1:0] input_col_b,
  output logic                    col_valid,
  output logic                    col_last,
  output logic                    frame_done,
  output logic                    dbg_stream
);

  localparam int DW = DATA_WIDTH;
  localparam int PW = 3 * DATA_WIDTH;
  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);

  typedef enum logic {FILL = 1'b0, STREAM = 1'b1} state_e;

  state_e          state_q, state_d, state_eff;
  logic [XW-1:0]   x_cnt_q, x_cnt_d, x_cur;
  logic [YW-1:0]   y_cnt_q, y_cnt_d, y_cur;
  logic [PW-1:0]   buf0_q [IMG_WIDTH];
  logic [PW-1:0]   buf1_q [IMG_WIDTH];
  logic [PW-1:0]   row1, row2;
  logic            row_end, frame_end, emit;
  logic [PW-1:0]   col_r_d, col_g_d, col_b_d;
  logic            col_valid_d, col_last_d, frame_done_d;

  // A start-of-frame pixel overrides the counters and the state for its own cycle.
  always_comb begin
    x_cur     = pix_sof ? '0 : x_cnt_q;
    y_cur     = pix_sof ? '0 : y_cnt_q;
    state_eff = pix_sof ? FILL : state_q;
    row_end   = (x_cur == XW'(IMG_WIDTH - 1));
    frame_end = row_end && (y_cur == YW'(IMG_HEIGHT - 1));
    row1      = buf0_q[x_cur];
    row2      = buf1_q[x_cur];
  end

  always_comb begin
    x_cnt_d = x_cnt_q;
    y_cnt_d = y_cnt_q;
    if (pix_valid) begin
      x_cnt_d = row_end ? '0 : x_cur + XW'(1);
      if (row_end) y_cnt_d = frame_end ? '0 : y_cur + YW'(1);
      else         y_cnt_d = y_cur;
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (pix_valid) begin
      case (state_eff)
        FILL:    state_d = (row_end && (y_cur == YW'(1))) ? STREAM : FILL;
        STREAM:  state_d = frame_end ? FILL : STREAM;
        default: state_d = FILL;
      endcase
    end
  end

  // FSM: outputs (registered one cycle later)
  always_comb begin
    emit         = pix_valid && (state_eff == STREAM);
    col_valid_d  = emit;
    col_last_d   = emit && row_end;
    frame_done_d = emit && frame_end;
    col_r_d      = input_col_r;
    col_g_d      = input_col_g;
    col_b_d      = input_col_b;
    if (emit) begin
      col_r_d = {pix_rgb[3*DW-1:2*DW], row1[3*DW-1:2*DW], row2[3*DW-1:2*DW]};
      col_g_d = {pix_rgb[2*DW-1:DW],   row1[2*DW-1:DW],   row2[2*DW-1:DW]};
      col_b_d = {pix_rgb[DW-1:0],      row1[DW-1:0],      row2[DW-1:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_cnt_q     <= '0;
      y_cnt_q     <= '0;
      input_col_r <= '0;
      input_col_g <= '0;
      input_col_b <= '0;
      col_valid   <= 1'b0;
      col_last    <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      x_cnt_q     <= x_cnt_d;
      y_cnt_q     <= y_cnt_d;
      input_col_r <= col_r_d;
      input_col_g <= col_g_d;
      input_col_b <= col_b_d;
      col_valid   <= col_valid_d;
      col_last    <= col_last_d;
      frame_done  <= frame_done_d;
    end
  end

  // Line buffers are not reset: FILL rewrites both rows before any read is emitted.
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      buf1_q[x_cur] <= row1;
      buf0_q[x_cur] <= pix_rgb;
    end
  end

  assign dbg_stream = (state_q == STREAM);

endmodule

// File: tb/tb_rgb_window_column_feeder.sv
// Bench for rgb_window_column_feeder: image-array reference model indexed by
// (x,y), directed frames from the feature list plus randomized frames.
module tb_rgb_window_column_feeder;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int PW = 24;

  logic          clk = 1'b0;
  logic          rst, pix_valid, pix_sof;
  logic [PW-1:0] pix_rgb;
  logic [PW-1:0] input_col_r, input_col_g, input_col_b;
  logic          col_valid, col_last, frame_done, dbg_stream;

  rgb_window_column_feeder #(.DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_rgb(pix_rgb),
    .input_col_r(input_col_r), .input_col_g(input_col_g), .input_col_b(input_col_b),
    .col_valid(col_valid), .col_last(col_last), .frame_done(frame_done),
    .dbg_stream(dbg_stream)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  int            mx, my;
  logic [PW-1:0] img [H][W];
  logic [3*PW-1:0] exp_q[$];
  logic [PW-1:0] hold_r, hold_g, hold_b;
  bit            hold_known;
  int            n_valid, n_last, n_done;

  function automatic logic [3*PW-1:0] column(input logic [PW-1:0] a, b, c);
    return {a[23:16], b[23:16], c[23:16], a[15:8], b[15:8], c[15:8], a[7:0], b[7:0], c[7:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; pix_valid = 1'b0; pix_sof = 1'b0;
    @(posedge clk); #1;
    chk("rst_col_valid", 32'(col_valid), 32'd0);
    chk("rst_col_last", 32'(col_last), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_col_r", 32'(input_col_r), 32'd0);
    chk("rst_col_g", 32'(input_col_g), 32'd0);
    chk("rst_col_b", 32'(input_col_b), 32'd0);
    mx = 0; my = 0;
    hold_r = '0; hold_g = '0; hold_b = '0; hold_known = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step(input bit v, input bit s, input logic [PW-1:0] px);
    bit ev, el, ed;
    logic [3*PW-1:0] ecol;
    @(negedge clk);
    pix_valid = v; pix_sof = s; pix_rgb = px;
    ev = 1'b0; el = 1'b0; ed = 1'b0;
    if (v) begin
      if (s) begin mx = 0; my = 0; end
      img[my][mx] = px;
      if (my >= 2) begin
        ev = 1'b1;
        el = (mx == W - 1);
        ed = el && (my == H - 1);
        exp_q.push_back(column(px, img[my-1][mx], img[my-2][mx]));
      end
      mx++;
      if (mx == W) begin
        mx = 0; my++;
        if (my == H) my = 0;
      end
    end
    @(posedge clk); #1;
    chk("col_valid", 32'(col_valid), 32'(ev));
    chk("col_last", 32'(col_last), 32'(el));
    chk("frame_done", 32'(frame_done), 32'(ed));
    if (ev) begin
      ecol = exp_q.pop_front();
      chk("col_r", 32'(input_col_r), 32'(ecol[71:48]));
      chk("col_g", 32'(input_col_g), 32'(ecol[47:24]));
      chk("col_b", 32'(input_col_b), 32'(ecol[23:0]));
      hold_r = ecol[71:48]; hold_g = ecol[47:24]; hold_b = ecol[23:0];
      hold_known = 1'b1;
      n_valid++;
      if (el) n_last++;
      if (ed) n_done++;
    end else if (!v && hold_known) begin
      chk("hold_r", 32'(input_col_r), 32'(hold_r));
      chk("hold_g", 32'(input_col_g), 32'(hold_g));
      chk("hold_b", 32'(input_col_b), 32'(hold_b));
    end else if (v) begin
      hold_known = 1'b0;
    end
  endtask

  // kind 0: gray base+y*4+x, 1: R=x G=16+y B=200, 2: random.  gaps 1: strict toggle, 2: random.
  task automatic send_frame(input int kind, input int base, input bit sof_first,
                            input int gaps, input int start, input int stop);
    logic [7:0]    v8;
    logic [PW-1:0] px;
    int            ng;
    for (int p = start; p < stop; p++) begin
      v8 = 8'(base + (p / W) * 4 + (p % W));
      case (kind)
        0:       px = {v8, v8, v8};
        1:       px = {8'(p % W), 8'(16 + p / W), 8'd200};
        default: px = PW'($urandom);
      endcase
      step(1'b1, sof_first && (p == 0), px);
      ng = (gaps == 1) ? 1 : (gaps == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int g = 0; g < ng; g++) step(1'b0, 1'($urandom_range(0, 1)), PW'($urandom));
    end
  endtask

  task automatic clear_counts();
    n_valid = 0; n_last = 0; n_done = 0;
  endtask

  initial begin
    rst = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0; pix_rgb = '0;
    mx = 0; my = 0; hold_known = 1'b0;
    hold_r = '0; hold_g = '0; hold_b = '0;
    clear_counts();
    do_reset();

    // continuous gray frame after reset
    send_frame(0, 0, 1'b0, 0, 0, 9);
    chk("t1_first_col_r", 32'(input_col_r), 32'h080400);
    send_frame(0, 0, 1'b0, 0, 9, W * H);
    chk("t1_n_valid", 32'(n_valid), 32'd8);
    chk("t1_n_last", 32'(n_last), 32'd2);
    chk("t1_n_done", 32'(n_done), 32'd1);

    // same frame with valid toggling
    do_reset(); clear_counts();
    send_frame(0, 0, 1'b0, 1, 0, W * H);
    chk("t2_n_valid", 32'(n_valid), 32'd8);
    chk("t2_n_last", 32'(n_last), 32'd2);

    // distinct channels, column at (1,2)
    clear_counts();
    send_frame(1, 0, 1'b1, 0, 0, 10);
    chk("t3_col_r", 32'(input_col_r), 32'h010101);
    chk("t3_col_g", 32'(input_col_g), 32'h121110);
    chk("t3_col_b", 32'(input_col_b), 32'hC8C8C8);
    send_frame(1, 0, 1'b1, 0, 10, W * H);

    // back-to-back frames with sof
    clear_counts();
    send_frame(0, 0, 1'b1, 0, 0, W * H);
    send_frame(0, 100, 1'b1, 0, 0, 9);
    chk("t4_first_col_r", 32'(input_col_r), 32'h6C6864);
    send_frame(0, 100, 1'b1, 0, 9, W * H);
    chk("t4_n_done", 32'(n_done), 32'd2);

    // sof at (2,2) aborts the frame
    clear_counts();
    send_frame(0, 0, 1'b1, 0, 0, 10);
    send_frame(0, 50, 1'b1, 0, 0, W * H);
    chk("t5_n_valid", 32'(n_valid), 32'd10);
    chk("t5_n_done", 32'(n_done), 32'd1);

    // reset during row 3, then a fresh frame without sof
    send_frame(0, 0, 1'b1, 0, 0, 14);
    do_reset(); clear_counts();
    send_frame(0, 0, 1'b0, 0, 0, W * H);
    chk("t6_n_valid", 32'(n_valid), 32'd8);
    chk("t6_n_last", 32'(n_last), 32'd2);
    chk("t6_n_done", 32'(n_done), 32'd1);

    // randomized frames, gaps, truncated frames and resets
    for (int f = 0; f < 12; f++) begin
      if ($urandom_range(0, 5) == 0) do_reset();
      send_frame(2, 0, 1'($urandom_range(0, 1)), 2, 0,
                 ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, W * H)) : W * H);
    end
    step(1'b0, 1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
